pixel_word_packer: RTL and testbench
====================================

// Module: pixel_word_packer
// PURPOSE
//  Packs a stream of narrow pixels (2^INLOGBITS bits) into 64-bit host words (2^OUTLOGBITS bits).
//  Sits between the pixel-rate app circuit and the host output stream. It is the return path of the
//  word-to-pixel unpacker on the input side.
//  Adds frame-end handling: in_last flushes a partial word, with a per-pixel keep mask and out_last.
// PARAMETERS
//  INLOGBITS   3  log2 of pixel width in bits (3 -> 8b, 4 -> 16b); must satisfy INLOGBITS <= OUTLOGBITS
//  OUTLOGBITS  6  log2 of output word width in bits (6 -> 64b)
//  derived: PW = 1<<INLOGBITS, OW = 1<<OUTLOGBITS, RATIO = OW/PW pixels per word
// PORTS
//  clk        in   1      sole clock; all state updates on posedge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      pixel valid
//  in_ready   out  1      packer accepts pixel this cycle
//  in_data    in   PW     pixel
//  in_last    in   1      pixel is the final pixel of a frame; flushes the word
//  out_valid  out  1      word valid
//  out_ready  in   1      sink accepts word this cycle
//  out_data   out  OW     packed word
//  out_keep   out  RATIO  bit i set = slot i holds a real pixel
//  out_last   out  1      word ends a frame
//  words_out  out  32     words delivered (present only with PIXEL_WORD_PACKER_STATS_EN)
// BEHAVIOUR
//  - Handshake: a transfer occurs on a cycle where valid && ready are both high. Transfers are evaluated at posedge clk.
//  - Pixel order: the first pixel of a word goes to bits [PW-1:0]. Slot i maps to [i*PW +: PW] (LSB-first).
//  - State: accumulator register acc[OW], fill count cnt (0..RATIO-1), accumulator keep mask,
//    and output register (out_data/out_keep/out_last/out_valid).
//  - in_ready = !rst && (!out_valid || out_ready). This is a combinational path from out_ready.
//  - On each accepted pixel:
//    - Write the pixel into slot cnt and set keep bit cnt.
//    - If cnt==RATIO-1 or in_last is high, the word completes:
//      - Move acc plus the new pixel into the output register.
//      - Set out_last to in_last and out_valid to 1.
//      - Clear acc, keep and cnt to 0.
//    - Otherwise cnt increments by 1.
//  - Latency: the word is valid on the cycle after the handshake of its final pixel.
//  - Throughput: 1 pixel/cycle sustained while out_ready is held high. No bubble at word boundaries.
//  - Partial word: unused slots are zero in out_data and 0 in out_keep. out_keep is always a contiguous
//    run of ones from bit 0.
//  - Output hold: while out_valid && !out_ready, out_data, out_keep and out_last are stable and no pixel
//    is accepted.
//  - On output handshake with no completing pixel that cycle, out_valid goes to 0 on the next cycle.
//  - Simultaneous output handshake and completing pixel: the register reloads and out_valid stays 1.
//  - in_last together with cnt==RATIO-1 produces a single full word with out_last=1. No empty word follows.
//  - RATIO==1: every pixel is a full word. out_keep=1. out_last=in_last. Still registered, 1-cycle latency.
//  - Reset (including mid-word or mid-hold):
//    - out_valid=0, out_data=0, out_keep=0, out_last=0, cnt=0, acc=0, words_out=0.
//    - Any partial or pending word is discarded. in_ready=0 while rst is high.
// CONFIGURATION
//  PIXEL_WORD_PACKER_STATS_EN defined:
//    - The words_out port exists. It increments by 1 on every out_valid && out_ready and wraps at 2^32.
//  Not defined:
//    - The words_out port and its counter are absent. All other behaviour is identical.
// TESTING (INLOGBITS=3, OUTLOGBITS=6 unless noted)
//  1 Full word: bytes 0x01..0x08 on consecutive cycles, out_ready=1, in_last=0 ->
//    out_data=0x0807060504030201, keep=0xFF, last=0, out_valid one cycle after the 8th handshake.
//  2 Partial flush: 0xAA, 0xBB, then 0xCC with in_last=1 -> out_data=0x0000000000CCBBAA, keep=0x07, last=1.
//    The next word starts at slot 0.
//  3 Backpressure: 16 bytes streamed with out_ready=0 ->
//    - in_ready drops the cycle after the 8th handshake; word 1 holds stable.
//    - Raising out_ready drains words in order, 0x0807060504030201 then 0x100F0E0D0C0B0A09.
//    - No pixel is lost or duplicated.
//  4 Streaming: 64 bytes with random in_valid gaps and out_ready=1 ->
//    - 8 words matching a reference model; zero-stall cycles where in_valid=1.
//    - Back-to-back completion with an output handshake keeps out_valid high.
//  5 Reset mid-word: 5 bytes, then rst pulsed for 1 cycle, then bytes 0x11..0x18 ->
//    - All outputs are 0 after reset.
//    - The first word is 0x1817161514131211; the stale bytes never appear.
//  6 INLOGBITS=6 passthrough plus STATS_EN: 3 words, last on the 3rd -> each out equals in, keep=1,
//    last only on the 3rd word, words_out=3.

Source files
------------

// File: rtl/pixel_word_packer.sv
// Packs narrow pixels LSB-first into wide host words; in_last flushes a partial word with a keep mask.
// Optional words_out delivery counter is enabled with `define PIXEL_WORD_PACKER_STATS_EN.
`timescale 1ns/1ps
module pixel_word_packer #(
  parameter int unsigned INLOGBITS  = 3,
  parameter int unsigned OUTLOGBITS = 6
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [(1<<INLOGBITS)-1:0]               in_data,
  input  logic                                    in_last,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [(1<<OUTLOGBITS)-1:0]              out_data,
  output logic [(1<<(OUTLOGBITS-INLOGBITS))-1:0]  out_keep,
  output logic                                    out_last
`ifdef PIXEL_WORD_PACKER_STATS_EN
  ,
  output logic [31:0]                             words_out
`endif
);

  localparam int unsigned PW    = 1 << INLOGBITS;
  localparam int unsigned OW    = 1 << OUTLOGBITS;
  localparam int unsigned RATIO = OW / PW;
  localparam int unsigned CW    = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic [OW-1:0]    acc_q, acc_d, acc_wr;
  logic [RATIO-1:0] keep_q, keep_d, keep_wr;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [OW-1:0]    out_data_q, out_data_d;
  logic [RATIO-1:0] out_keep_q, out_keep_d;
  logic             out_last_q, out_last_d;
  logic             out_valid_q, out_valid_d;
  logic             accept, complete;

  assign in_ready = !rst && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    acc_wr  = acc_q;
    keep_wr = keep_q;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (cnt_q == CW'(i)) begin
        acc_wr[i*PW +: PW] = in_data;
        keep_wr[i]         = 1'b1;
      end
    end
    complete = accept && (in_last || (cnt_q == CW'(RATIO - 1)));

    acc_d       = acc_q;
    keep_d      = keep_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;

    if (out_ready) out_valid_d = 1'b0;
    // A completing pixel is only accepted when the output slot is free or draining, so reload wins.
    if (complete) begin
      out_data_d  = acc_wr;
      out_keep_d  = keep_wr;
      out_last_d  = in_last;
      out_valid_d = 1'b1;
      acc_d       = '0;
      keep_d      = '0;
      cnt_d       = '0;
    end else if (accept) begin
      acc_d  = acc_wr;
      keep_d = keep_wr;
      cnt_d  = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      keep_q      <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      keep_q      <= keep_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

`ifdef PIXEL_WORD_PACKER_STATS_EN
  logic [31:0] words_out_q, words_out_d;

  always_comb begin
    words_out_d = words_out_q;
    if (out_valid_q && out_ready) words_out_d = words_out_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) words_out_q <= '0;
    else     words_out_q <= words_out_d;
  end

  assign words_out = words_out_q;
`endif

endmodule

// File: tb/tb_pixel_word_packer.sv
// Randomised and directed bench for pixel_word_packer: 8b->64b instance against a queue-based word
// model, plus a 64b->64b passthrough instance.
`timescale 1ns/1ps
module tb_pixel_word_packer;
  localparam int unsigned PW    = 8;
  localparam int unsigned RATIO = 8;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, in_last, out_valid, out_ready, out_last;
  logic [7:0]  in_data, out_keep;
  logic [63:0] out_data;

  logic        p_in_valid, p_in_ready, p_in_last, p_out_valid, p_out_ready, p_out_last;
  logic [63:0] p_in_data, p_out_data;
  logic [0:0]  p_out_keep;
`ifdef PIXEL_WORD_PACKER_STATS_EN
  logic [31:0] words_out, p_words_out;
`endif

  pixel_word_packer #(.INLOGBITS(3), .OUTLOGBITS(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_keep(out_keep), .out_last(out_last)
`ifdef PIXEL_WORD_PACKER_STATS_EN
    , .words_out(words_out)
`endif
  );

  pixel_word_packer #(.INLOGBITS(6), .OUTLOGBITS(6)) dut_p (
    .clk(clk), .rst(rst), .in_valid(p_in_valid), .in_ready(p_in_ready), .in_data(p_in_data),
    .in_last(p_in_last), .out_valid(p_out_valid), .out_ready(p_out_ready), .out_data(p_out_data),
    .out_keep(p_out_keep), .out_last(p_out_last)
`ifdef PIXEL_WORD_PACKER_STATS_EN
    , .words_out(p_words_out)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: collects accepted pixels into words and queues the expected output.
  logic [63:0] m_word;
  int          m_n;
  logic [63:0] q_data[$];
  logic [7:0]  q_keep[$];
  logic        q_last[$];
  int          words_seen;
  logic        hold_pend;
  logic [63:0] hold_data;
  logic [7:0]  hold_keep;
  logic        hold_last;

  always @(negedge clk) begin
    if (rst) begin
      m_word = '0;
      m_n = 0;
      q_data.delete();
      q_keep.delete();
      q_last.delete();
      hold_pend = 1'b0;
      words_seen = 0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", out_data, hold_data);
        check("hold_keep", 64'(out_keep), 64'(hold_keep));
        check("hold_last", 64'(out_last), 64'(hold_last));
      end
      if (out_valid && out_ready) begin
        if (q_data.size() == 0) begin
          check("unexpected_word", 64'(out_valid), 64'd0);
        end else begin
          check("word_data", out_data, q_data.pop_front());
          check("word_keep", 64'(out_keep), 64'(q_keep.pop_front()));
          check("word_last", 64'(out_last), 64'(q_last.pop_front()));
        end
        words_seen++;
      end
      hold_pend = out_valid && !out_ready;
      hold_data = out_data;
      hold_keep = out_keep;
      hold_last = out_last;
      if (in_valid && in_ready) begin
        m_word = m_word | (64'(in_data) << (m_n * PW));
        m_n++;
        if (m_n == RATIO || in_last) begin
          q_data.push_back(m_word);
          q_keep.push_back(8'((1 << m_n) - 1));
          q_last.push_back(in_last);
          m_word = '0;
          m_n = 0;
        end
      end
    end
  end

  logic rand_ready = 1'b0;

  task automatic next_cycle();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [7:0] d, input logic l, input logic must_accept);
    int unsigned t = 0;
    logic done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!done) begin
      @(negedge clk);
      if (must_accept && t == 0) check("no_stall", 64'(in_ready), 64'd1);
      if (in_ready) begin
        done = 1'b1;
      end else if (t > 200) begin
        check("send_timeout", 64'd0, 64'd1);
        done = 1'b1;
      end else begin
        t++;
        next_cycle();
      end
    end
    next_cycle();
  endtask

  task automatic idle(input int unsigned n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) next_cycle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    p_in_valid = 1'b0; p_in_data = '0; p_in_last = 1'b0; p_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", out_data, 64'd0);
    check("rst_keep", 64'(out_keep), 64'd0);
    check("rst_last", 64'(out_last), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    next_cycle();

    // Full word and one-cycle latency
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send(8'(i), 1'b0, 1'b1);
      if (i == 7) check("t1_no_early", 64'(out_valid), 64'd0);
    end
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_data", out_data, 64'h0807060504030201);
    check("t1_keep", 64'(out_keep), 64'hFF);
    check("t1_last", 64'(out_last), 64'd0);
    idle(2);

    // Partial flush, then next word restarts at slot 0
    send(8'hAA, 1'b0, 1'b1);
    send(8'hBB, 1'b0, 1'b1);
    send(8'hCC, 1'b1, 1'b1);
    check("t2_data", out_data, 64'h0000000000CCBBAA);
    check("t2_keep", 64'(out_keep), 64'h07);
    check("t2_last", 64'(out_last), 64'd1);
    send(8'h5A, 1'b1, 1'b1);
    check("t2_restart_data", out_data, 64'h5A);
    check("t2_restart_keep", 64'(out_keep), 64'h01);
    idle(2);

    // Backpressure: 9th pixel must stall until the first word drains
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'd9;
    @(negedge clk);
    check("t3_in_ready_low", 64'(in_ready), 64'd0);
    check("t3_held_data", out_data, 64'h0807060504030201);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 9; i <= 16; i++) send(8'(i), 1'b0, 1'b1);
    check("t3_word2_valid", 64'(out_valid), 64'd1);
    check("t3_word2_data", out_data, 64'h100F0E0D0C0B0A09);
    idle(2);

    // Streaming with random input gaps; no stalls allowed
    for (int k = 0; k < 64; k++) begin
      while ($urandom_range(0, 2) == 0) idle(1);
      send(8'($urandom), 1'b0, 1'b1);
    end
    idle(2);

    // Random backpressure and random frame ends
    rand_ready = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send(8'($urandom), 1'($urandom_range(0, 9) == 0), 1'b0);
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    idle(4);
    check("queue_empty", 64'(q_data.size()), 64'd0);
`ifdef PIXEL_WORD_PACKER_STATS_EN
    check("words_out", 64'(words_out), 64'(words_seen));
`endif

    // Reset mid-word
    for (int i = 0; i < 5; i++) send(8'hE1 + 8'(i), 1'b0, 1'b1);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("t5_in_ready_rst", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t5_valid", 64'(out_valid), 64'd0);
    check("t5_data", out_data, 64'd0);
    check("t5_keep", 64'(out_keep), 64'd0);
    check("t5_last", 64'(out_last), 64'd0);
    for (int i = 0; i < 8; i++) send(8'h11 + 8'(i), 1'b0, 1'b1);
    check("t5_word", out_data, 64'h1817161514131211);
    check("t5_word_keep", 64'(out_keep), 64'hFF);
    idle(2);

    // Reset while a word is held
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(8'h30 + 8'(i), 1'b0, 1'b1);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t5_hold_rst_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    send(8'h77, 1'b1, 1'b1);
    check("t5_hold_rst_next", out_data, 64'h77);
    idle(2);

    // Passthrough instance: every pixel is a full word
    p_out_ready = 1'b1;
    for (int w = 0; w < 3; w++) begin
      logic [63:0] v;
      v = {$urandom, $urandom};
      p_in_valid = 1'b1;
      p_in_data  = v;
      p_in_last  = (w == 2);
      @(negedge clk);
      check("t6_in_ready", 64'(p_in_ready), 64'd1);
      @(posedge clk);
      #1;
      check("t6_valid", 64'(p_out_valid), 64'd1);
      check("t6_data", p_out_data, v);
      check("t6_keep", 64'(p_out_keep), 64'd1);
      check("t6_last", 64'(p_out_last), (w == 2) ? 64'd1 : 64'd0);
    end
    p_in_valid = 1'b0;
    p_in_last  = 1'b0;
    @(posedge clk);
    #1;
    check("t6_idle_valid", 64'(p_out_valid), 64'd0);
`ifdef PIXEL_WORD_PACKER_STATS_EN
    check("t6_words_out", 64'(p_words_out), 64'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
